// File: rtl/blackparrot_fpga_host_write_arbiter.sv
// Shares the host-to-BP write command port among num_req_p requesters: round-robin
// arbitration into a one-entry registered stage, write credit tracking and fence ordering.

module blackparrot_fpga_host_write_arbiter_checker #(
   parameter int unsigned num_req_p = 2
) (
   input logic                 clk_i,
   input logic                 rst_n_i,
   input logic [num_req_p-1:0] req_v_i,
   input logic [num_req_p-1:0] req_yumi_i,
   input logic                 wresp_v_i,
   input logic                 load_i,
   input logic                 empty_count_i
);
   // A response with nothing outstanding and nothing loading means the AXI side lost count.
   assert property (@(posedge clk_i) disable iff (!rst_n_i) !(wresp_v_i && empty_count_i && !load_i));
   assert property (@(posedge clk_i) disable iff (!rst_n_i) $onehot0(req_yumi_i));
   assert property (@(posedge clk_i) disable iff (!rst_n_i) (req_yumi_i & ~req_v_i) == '0);
endmodule

module blackparrot_fpga_host_write_arbiter #(
   parameter int unsigned num_req_p    = 2,
   parameter int unsigned addr_width_p = 64,
   parameter int unsigned data_width_p = 64,
   parameter int unsigned credits_p    = 64
) (
   input  logic                                m_axi_aclk,
   input  logic                                m_axi_aresetn,
   input  logic [num_req_p-1:0]                req_v_i,
   input  logic [num_req_p-1:0]                req_fence_i,
   input  logic [num_req_p*addr_width_p-1:0]   req_addr_i,
   input  logic [num_req_p*data_width_p-1:0]   req_data_i,
   input  logic [num_req_p*3-1:0]              req_size_i,
   output logic [num_req_p-1:0]                req_yumi_o,
   output logic                                cmd_v_o,
   output logic                                cmd_w_o,
   output logic [addr_width_p-1:0]             cmd_addr_o,
   output logic [data_width_p-1:0]             cmd_data_o,
   output logic [2:0]                          cmd_size_o,
   input  logic                                cmd_ready_and_i,
   input  logic                                wresp_v_i,
   output logic [$clog2(credits_p+1)-1:0]      outstanding_o,
   output logic                                idle_o
);
   localparam int unsigned idx_width_lp = $clog2(num_req_p);
   localparam int unsigned cnt_width_lp = $clog2(credits_p + 1);
   localparam logic [cnt_width_lp-1:0] credits_lp = cnt_width_lp'(credits_p);
   localparam logic [0:0] ST_ARB   = 1'b0;
   localparam logic [0:0] ST_FENCE = 1'b1;

   // base + off modulo num_req_p; both operands are already below num_req_p.
   function automatic logic [idx_width_lp-1:0] wrap_inc(input logic [idx_width_lp-1:0] base,
                                                        input int unsigned off);
      int unsigned sum;
      sum = 32'(base) + off;
      sum = (sum >= num_req_p) ? sum - num_req_p : sum;
      return sum[idx_width_lp-1:0];
   endfunction

   logic [0:0]              state_q, state_d;
   logic [idx_width_lp-1:0] rr_ptr_q, rr_ptr_d;
   logic [idx_width_lp-1:0] grant_q, grant_d;
   logic [idx_width_lp-1:0] win_idx_s, cand_s;
   logic                    win_found_s;
   logic                    cmd_v_q, cmd_v_d;
   logic [addr_width_p-1:0] addr_q, addr_d;
   logic [data_width_p-1:0] data_q, data_d;
   logic [2:0]              size_q, size_d;
   logic [cnt_width_lp-1:0] outstanding_q, outstanding_d;
   logic [num_req_p-1:0]    yumi_s;
   logic                    load_s;
   logic                    drain_s;
   logic                    can_load_s;
   logic                    credit_ok_s;

   assign drain_s     = cmd_v_q & cmd_ready_and_i;
   assign can_load_s  = ~cmd_v_q | drain_s;
   assign credit_ok_s = (outstanding_q < credits_lp);

   // Round-robin search starting at the pointer; computed even when credits block issue.
   always_comb begin
      win_found_s = 1'b0;
      win_idx_s   = '0;
      cand_s      = '0;
      for (int unsigned i = 0; i < num_req_p; i++) begin
         cand_s      = wrap_inc(rr_ptr_q, i);
         win_idx_s   = (!win_found_s && req_v_i[cand_s]) ? cand_s : win_idx_s;
         win_found_s = win_found_s | req_v_i[cand_s];
      end
   end

   // Arbitration / fence FSM: decides yumi, load and the next pointer.
   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      rr_ptr_d = rr_ptr_q;
      yumi_s   = '0;
      load_s   = 1'b0;
      case (state_q)
         ST_ARB: begin
            if (win_found_s && req_fence_i[win_idx_s]) begin
               state_d = ST_FENCE;
               grant_d = win_idx_s;
            end else if (win_found_s && can_load_s && credit_ok_s) begin
               yumi_s[win_idx_s] = 1'b1;
               load_s            = 1'b1;
               rr_ptr_d          = wrap_inc(win_idx_s, 32'd1);
            end else begin
               rr_ptr_d = rr_ptr_q;
            end
         end
         ST_FENCE: begin
            // Every earlier write must have left the stage and been responded to.
            if (!cmd_v_q && (outstanding_q == '0) && req_v_i[grant_q]) begin
               yumi_s[grant_q] = 1'b1;
               rr_ptr_d        = wrap_inc(grant_q, 32'd1);
               state_d         = ST_ARB;
            end else begin
               state_d = ST_FENCE;
            end
         end
         default: begin
            state_d = ST_ARB;
         end
      endcase
   end

   // One-entry output stage: a load may replace an entry draining this cycle.
   always_comb begin
      cmd_v_d = cmd_v_q;
      addr_d  = addr_q;
      data_d  = data_q;
      size_d  = size_q;
      if (load_s) begin
         cmd_v_d = 1'b1;
         addr_d  = req_addr_i[32'(win_idx_s)*addr_width_p +: addr_width_p];
         data_d  = req_data_i[32'(win_idx_s)*data_width_p +: data_width_p];
         size_d  = req_size_i[32'(win_idx_s)*3 +: 3];
      end else if (drain_s) begin
         cmd_v_d = 1'b0;
      end else begin
         cmd_v_d = cmd_v_q;
      end
   end

   // Outstanding write count; a response at zero with no load holds zero.
   always_comb begin
      outstanding_d = outstanding_q;
      if (load_s && !wresp_v_i) begin
         outstanding_d = outstanding_q + cnt_width_lp'(1);
      end else if (!load_s && wresp_v_i && (outstanding_q != '0)) begin
         outstanding_d = outstanding_q - cnt_width_lp'(1);
      end else begin
         outstanding_d = outstanding_q;
      end
   end

   // State registers.
   always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
      if (!m_axi_aresetn) begin
         state_q       <= ST_ARB;
         rr_ptr_q      <= '0;
         grant_q       <= '0;
         cmd_v_q       <= 1'b0;
         addr_q        <= '0;
         data_q        <= '0;
         size_q        <= 3'd0;
         outstanding_q <= '0;
      end else begin
         state_q       <= state_d;
         rr_ptr_q      <= rr_ptr_d;
         grant_q       <= grant_d;
         cmd_v_q       <= cmd_v_d;
         addr_q        <= addr_d;
         data_q        <= data_d;
         size_q        <= size_d;
         outstanding_q <= outstanding_d;
      end
   end

   assign req_yumi_o    = yumi_s & {num_req_p{m_axi_aresetn}};
   assign cmd_v_o       = cmd_v_q;
   assign cmd_w_o       = 1'b1;
   assign cmd_addr_o    = addr_q;
   assign cmd_data_o    = data_q;
   assign cmd_size_o    = size_q;
   assign outstanding_o = outstanding_q;
   assign idle_o        = (state_q == ST_ARB) & ~cmd_v_q & (outstanding_q == '0);

   blackparrot_fpga_host_write_arbiter_checker #(
      .num_req_p(num_req_p)
   ) u_checker (
      .clk_i         (m_axi_aclk),
      .rst_n_i       (m_axi_aresetn),
      .req_v_i       (req_v_i),
      .req_yumi_i    (req_yumi_o),
      .wresp_v_i     (wresp_v_i),
      .load_i        (load_s),
      .empty_count_i (outstanding_q == '0)
   );
endmodule
